// File: rtl/dpdm_pkg.sv
// dpdm_pkg: shared types, packet timing constants and length lookup for the DP/DM transfer sequencer
package dpdm_pkg;
   typedef enum logic [1:0] {
      NONE      = 2'b00,
      TOKEN     = 2'b01,
      DATA      = 2'b10,
      HANDSHAKE = 2'b11
   } pkt_type_t;
   typedef enum logic [1:0] {IDLE, TX, TURN, RX} xfer_state_t;
   localparam logic [6:0] TOK_LIM  = 7'd32;
   localparam logic [6:0] DATA_LIM = 7'd92;
   localparam logic [6:0] HS_LIM   = 7'd12;
   // EOP tail after the stream: two SE0 cycles then one J cycle
   localparam logic [6:0] EOP_CYC  = 7'd3;
   function automatic logic [6:0] lim_of(pkt_type_t t);
      return t == TOKEN ? TOK_LIM : t == DATA ? DATA_LIM : t == HANDSHAKE ? HS_LIM : 7'd0;
   endfunction
endpackage

// File: rtl/dpdm_xfer_ctrl_if.sv
// dpdm_xfer_ctrl_if: request/line-control bundle between protocol FSM, dpdm block and sequencer
// master: protocol FSM / dpdm receiver side (drives tx_req, tx_type, rx_expect, r_done)
// slave:  the sequencer (drives tx_ack, pkt_type, bit_req, re, busy, xfer_done, xfer_timeout)
interface dpdm_xfer_ctrl_if;
   import dpdm_pkg::*;
   logic       tx_req;
   logic [1:0] tx_type;
   logic       rx_expect;
   logic       tx_ack;
   pkt_type_t  pkt_type;
   logic       bit_req;
   logic       re;
   logic       r_done;
   logic       busy;
   logic       xfer_done;
   logic       xfer_timeout;
   modport master (
      output tx_req, tx_type, rx_expect, r_done,
      input  tx_ack, pkt_type, bit_req, re, busy, xfer_done, xfer_timeout
   );
   modport slave (
      input  tx_req, tx_type, rx_expect, r_done,
      output tx_ack, pkt_type, bit_req, re, busy, xfer_done, xfer_timeout
   );
endinterface

// File: rtl/dpdm_phase_timer.sv
// dpdm_phase_timer: loadable 8-bit down-counter timing the TX, TURN and RX phases
// ports: clk, rst; load/load_val reload the count; en decrements (stops at 0);
//        count is the current value; expire is high while count is 0 (last phase cycle)
module dpdm_phase_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       en,
   output logic [7:0] count,
   output logic       expire
);
   logic [7:0] count_q, count_d;
   always_comb count_d = load ? load_val : (en && count_q != 8'd0) ? count_q - 8'd1 : count_q;
   always_ff @(posedge clk) count_q <= rst ? 8'd0 : count_d;
   assign count  = count_q;
   assign expire = count_q == 8'd0;
endmodule

// File: rtl/dpdm_xfer_ctrl.sv
// dpdm_xfer_ctrl: host-side DP/DM sequencer (TX packet, bus turnaround, bounded read window)
// ports: clk, rst (sync, active-high); bus (dpdm_xfer_ctrl_if.slave) carrying the request,
//        line-control and completion signals
// optional: define DPDM_XFER_RETRY_EN to retransmit up to MAX_RETRY times after RX timeouts
module dpdm_xfer_ctrl
   import dpdm_pkg::*;
#(
   parameter int TURN_CYC   = 2,
   parameter int RX_TIMEOUT = 18,
   parameter int MAX_RETRY  = 3
) (
   input logic             clk,
   input logic             rst,
   dpdm_xfer_ctrl_if.slave bus
);
   localparam logic [7:0] TURN_LD = 8'(TURN_CYC - 1);
   localparam logic [7:0] RX_LD   = 8'(RX_TIMEOUT - 1);

   if (TURN_CYC < 1 || TURN_CYC > 15 || RX_TIMEOUT < 1 || RX_TIMEOUT > 255 ||
       MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_param_err
      $error("dpdm_xfer_ctrl: parameter out of legal range");
   end

   // TX timer load: stream LIM+1 cycles plus EOP tail, minus one for the count-to-zero
   function automatic logic [7:0] tx_load(pkt_type_t t);
      return {1'b0, lim_of(t)} + {1'b0, EOP_CYC};
   endfunction

   xfer_state_t state_q, state_d;
   pkt_type_t   typ_q, typ_d;
   logic        exp_q, exp_d, done_q, done_d, to_q, to_d;
   logic        load, expire, can_retry;
   logic [7:0]  load_val, count;

   dpdm_phase_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .en       (state_q != IDLE),
      .count    (count),
      .expire   (expire)
   );

`ifdef DPDM_XFER_RETRY_EN
   logic [2:0] retry_q, retry_d;
   assign can_retry = int'(retry_q) < MAX_RETRY;
   always_comb retry_d = state_d == IDLE ? 3'd0 :
                         (state_q == RX && state_d == TX) ? retry_q + 3'd1 : retry_q;
   always_ff @(posedge clk) retry_q <= rst ? 3'd0 : retry_d;
`else
   assign can_retry = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      typ_d    = typ_q;
      exp_d    = exp_q;
      done_d   = 1'b0;
      to_d     = 1'b0;
      load     = 1'b0;
      load_val = 8'd0;
      case (state_q)
         IDLE: if (bus.tx_ack) begin
            state_d  = TX;
            typ_d    = pkt_type_t'(bus.tx_type);
            exp_d    = bus.rx_expect;
            load     = 1'b1;
            load_val = tx_load(pkt_type_t'(bus.tx_type));
         end
         TX: if (expire) begin
            state_d  = TURN;
            load     = 1'b1;
            load_val = TURN_LD;
         end
         TURN: if (expire) begin
            state_d  = exp_q ? RX : IDLE;
            done_d   = !exp_q;
            load     = 1'b1;
            load_val = RX_LD;
         end
         RX: if (bus.r_done) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else if (expire && can_retry) begin
            state_d  = TX;
            load     = 1'b1;
            load_val = tx_load(typ_q);
         end else if (expire) begin
            state_d = IDLE;
            to_d    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         typ_q   <= NONE;
         exp_q   <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         typ_q   <= typ_d;
         exp_q   <= exp_d;
         done_q  <= done_d;
         to_q    <= to_d;
      end
   end

   assign bus.tx_ack       = !rst && state_q == IDLE && bus.tx_req && bus.tx_type != 2'b00;
   assign bus.pkt_type     = state_q == TX ? typ_q : NONE;
   // stream bits are requested while more than the EOP tail remains
   assign bus.bit_req      = state_q == TX && count >= {1'b0, EOP_CYC};
   assign bus.re           = state_q == RX;
   assign bus.busy         = state_q != IDLE;
   assign bus.xfer_done    = done_q;
   assign bus.xfer_timeout = to_q;
endmodule
